line_xfer_engine: RTL and testbench

- Memory-side sequencer directly downstream of the cache controller.
- Accepts one line-level command per transaction (evict, refill, or evict-then-refill) and expands it into word-level val/rdy requests to memory.
- Counts write acknowledgements and read responses.
- Streams refill words into the data array and pulses completion back to the controller.

---
 rtl/line_xfer_engine.sv | 162 ++++++++++++++++
 tb/tb_line_xfer_engine.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_xfer_engine.sv
// Line transfer engine: expands evict/refill line commands into
// word-level memory requests and streams refill words into the data array.
`timescale 1ns/1ps
module line_xfer_engine #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int WORDS   = 16,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_val,
    output logic                     cmd_rdy,
    input  logic [1:0]               cmd_type,
    input  logic [ADDR_W-1:0]        cmd_evict_addr,
    input  logic [ADDR_W-1:0]        cmd_refill_addr,
    input  logic                     ev_data_val,
    output logic                     ev_data_rdy,
    input  logic [DATA_W-1:0]        ev_data,
    output logic                     mem_req_val,
    input  logic                     mem_req_rdy,
    output logic                     mem_req_type,
    output logic [ADDR_W-1:0]        mem_req_addr,
    output logic [DATA_W-1:0]        mem_req_data,
    input  logic                     mem_resp_val,
    output logic                     mem_resp_rdy,
    input  logic [DATA_W-1:0]        mem_resp_data,
    output logic                     fill_wen,
    output logic [$clog2(WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]        fill_data,
    output logic                     done
);
    localparam int IW     = $clog2(WORDS);
    localparam int CW     = IW + 1;
    localparam int STRIDE = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE, EV_ISSUE, EV_DRAIN, RF_ISSUE, RF_DRAIN, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     req_cnt_q, req_cnt_d;
    logic [CW-1:0]     rsp_cnt_q, rsp_cnt_d;
    logic [1:0]        type_q, type_d;
    logic [ADDR_W-1:0] ev_base_q, ev_base_d;
    logic [ADDR_W-1:0] rf_base_q, rf_base_d;
    logic [CW-1:0]     outstanding;
    logic              can_issue;
    logic              in_rf;
    logic [ADDR_W-1:0] offset;

    always_comb begin
        state_d      = state_q;
        req_cnt_d    = req_cnt_q;
        rsp_cnt_d    = rsp_cnt_q;
        type_d       = type_q;
        ev_base_d    = ev_base_q;
        rf_base_d    = rf_base_q;
        cmd_rdy      = 1'b0;
        ev_data_rdy  = 1'b0;
        mem_req_val  = 1'b0;
        mem_req_type = 1'b0;
        mem_req_addr = '0;
        mem_req_data = '0;
        mem_resp_rdy = 1'b0;
        fill_wen     = 1'b0;
        fill_idx     = '0;
        fill_data    = '0;
        done         = 1'b0;
        outstanding  = req_cnt_q - rsp_cnt_q;
        can_issue    = (req_cnt_q < CW'(WORDS)) &&
                       (outstanding < CW'(MAX_OUT));
        in_rf        = (state_q == RF_ISSUE) || (state_q == RF_DRAIN);
        offset       = ADDR_W'(req_cnt_q) * ADDR_W'(STRIDE);

        unique case (state_q)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_val) begin
                    type_d    = cmd_type;
                    ev_base_d = cmd_evict_addr;
                    rf_base_d = cmd_refill_addr;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    state_d   = (cmd_type == 2'd1 || cmd_type == 2'd2) ?
                                EV_ISSUE : RF_ISSUE;
                end
            end
            EV_ISSUE: begin
                mem_resp_rdy = 1'b1;
                mem_req_val  = ev_data_val && can_issue;
                mem_req_type = 1'b1;
                mem_req_addr = ev_base_q + offset;
                mem_req_data = ev_data;
                // victim word leaves the array only with an accepted write
                ev_data_rdy  = mem_req_val && mem_req_rdy;
            end
            EV_DRAIN: mem_resp_rdy = 1'b1;
            RF_ISSUE: begin
                mem_resp_rdy = 1'b1;
                mem_req_val  = can_issue;
                mem_req_addr = rf_base_q + offset;
            end
            RF_DRAIN: mem_resp_rdy = 1'b1;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (mem_req_val && mem_req_rdy)
            req_cnt_d = req_cnt_q + CW'(1);
        if (mem_resp_val && mem_resp_rdy) begin
            rsp_cnt_d = rsp_cnt_q + CW'(1);
            if (in_rf) begin
                fill_wen  = 1'b1;
                fill_idx  = rsp_cnt_q[IW-1:0];
                fill_data = mem_resp_data;
            end
        end

        unique case (state_q)
            EV_ISSUE:
                if (req_cnt_d == CW'(WORDS)) state_d = EV_DRAIN;
            EV_DRAIN:
                // all write acks land before the first refill read
                if (rsp_cnt_q == CW'(WORDS)) begin
                    if (type_q == 2'd2) begin
                        state_d   = RF_ISSUE;
                        req_cnt_d = '0;
                        rsp_cnt_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            RF_ISSUE:
                if (req_cnt_d == CW'(WORDS)) state_d = RF_DRAIN;
            RF_DRAIN:
                if (rsp_cnt_q == CW'(WORDS)) state_d = DONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            type_q    <= '0;
            ev_base_q <= '0;
            rf_base_q <= '0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            type_q    <= type_d;
            ev_base_q <= ev_base_d;
            rf_base_q <= rf_base_d;
        end
    end
endmodule

// File: tb/tb_line_xfer_engine.sv
// Scoreboard bench for line_xfer_engine: directed line commands against a
// queued memory model; a monitor pops expected requests/fills/done.
`timescale 1ns/1ps
module tb_line_xfer_engine;
    localparam int WORDS   = 16;
    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_val = 1'b0;
    logic        cmd_rdy;
    logic [1:0]  cmd_type = '0;
    logic [31:0] cmd_evict_addr = '0;
    logic [31:0] cmd_refill_addr = '0;
    logic        ev_data_val = 1'b0;
    logic        ev_data_rdy;
    logic [31:0] ev_data = '0;
    logic        mem_req_val;
    logic        mem_req_rdy = 1'b0;
    logic        mem_req_type;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_resp_val = 1'b0;
    logic        mem_resp_rdy;
    logic [31:0] mem_resp_data = '0;
    logic        fill_wen;
    logic [3:0]  fill_idx;
    logic [31:0] fill_data;
    logic        done;

    always #5 clk = ~clk;

    line_xfer_engine #(
        .ADDR_W(32), .DATA_W(32), .WORDS(WORDS), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_type(cmd_type),
        .cmd_evict_addr(cmd_evict_addr), .cmd_refill_addr(cmd_refill_addr),
        .ev_data_val(ev_data_val), .ev_data_rdy(ev_data_rdy),
        .ev_data(ev_data),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_req_type(mem_req_type), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
        .mem_resp_data(mem_resp_data),
        .fill_wen(fill_wen), .fill_idx(fill_idx), .fill_data(fill_data),
        .done(done)
    );

    typedef struct packed {logic t; logic [31:0] a; logic [31:0] d;} req_t;
    typedef struct packed {logic [3:0] i; logic [31:0] d;} fill_t;
    typedef struct packed {int total; logic ev;} done_t;
    typedef struct packed {logic t; logic [31:0] a; int due;} pend_t;

    req_t  exp_req[$];
    fill_t exp_fill[$];
    done_t exp_done[$];
    int    n_chk = 0;
    int    n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return 32'hD000_0000 | a;
    endfunction

    // memory model and victim-data source
    pend_t       pend[$];
    int          cyc = 0;
    int          wr_lat = 1;
    int          rd_lat = 1;
    bit          throttle = 0;
    logic        req_hs = 1'b0;
    logic        req_tc = 1'b0;
    logic [31:0] req_ac = '0;
    logic        resp_hs = 1'b0;
    logic        cmd_hs = 1'b0;
    logic        cmd_ev = 1'b0;
    int          ev_idx = WORDS;
    int          rd_hs_cnt = 0;

    always begin
        @(negedge clk);
        cyc++;
        if (!reset) begin
            pend.delete();
            ev_idx = WORDS;
        end else begin
            if (resp_hs && pend.size() > 0) void'(pend.pop_front());
            if (req_hs)
                pend.push_back('{t: req_tc, a: req_ac,
                    due: cyc + (req_tc ? wr_lat : rd_lat) - 1});
            if (cmd_hs && cmd_ev) ev_idx = 0;
        end
        mem_req_rdy = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend.size() > 0 && pend[0].due <= cyc &&
            (!throttle || $urandom_range(0, 1) == 1)) begin
            mem_resp_val  = 1'b1;
            mem_resp_data = pend[0].t ? 32'hDEAD_BEEF : rd_data(pend[0].a);
        end else begin
            mem_resp_val  = 1'b0;
            mem_resp_data = '0;
        end
        ev_data_val = ev_idx < WORDS;
        ev_data     = 32'(32'hA0 + ev_idx);
        #1;
        req_hs  = mem_req_val && mem_req_rdy;
        req_tc  = mem_req_type;
        req_ac  = mem_req_addr;
        resp_hs = mem_resp_val && mem_resp_rdy;
        cmd_hs  = cmd_val && cmd_rdy;
        cmd_ev  = cmd_type == 2'd1 || cmd_type == 2'd2;
        if (ev_data_val && ev_data_rdy) ev_idx++;
        if (req_hs && !mem_req_type) rd_hs_cnt++;
    end

    // monitor / scoreboard
    logic   prev_stall = 1'b0;
    req_t   prev_req = '0;
    int     mon_out = 0;
    int     mon_wr_acks = 0;
    int     mon_reqs = 0;
    int     mon_resps = 0;
    int     done_cnt = 0;
    logic   mon_types[$];

    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            prev_stall  = 1'b0;
            mon_out     = 0;
            mon_wr_acks = 0;
            mon_reqs    = 0;
            mon_resps   = 0;
            mon_types.delete();
        end else begin
            if (prev_stall) begin
                chk("hold_val", 32'(mem_req_val), 32'd1);
                chk("hold_addr", mem_req_addr, prev_req.a);
                chk("hold_data", mem_req_data, prev_req.d);
                chk("hold_type", 32'(mem_req_type), 32'(prev_req.t));
            end
            if (mem_req_val && mem_req_rdy) begin
                req_t e;
                chk("outstanding_le_max", 32'(mon_out < MAX_OUT), 32'd1);
                if (exp_req.size() == 0) begin
                    n_chk++;
                    $display("FAIL req_extra: got addr %h, none expected",
                             mem_req_addr);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_type", 32'(mem_req_type), 32'(e.t));
                    chk("req_addr", mem_req_addr, e.a);
                    if (e.t) chk("req_wdata", mem_req_data, e.d);
                end
                if (!mem_req_type && exp_done.size() > 0 && exp_done[0].ev)
                    chk("read_after_acks", 32'(mon_wr_acks), 32'd16);
                mon_types.push_back(mem_req_type);
                mon_reqs++;
                mon_out++;
            end
            if (mem_resp_val && mem_resp_rdy) begin
                if (mon_types.size() > 0 && mon_types.pop_front())
                    mon_wr_acks++;
                mon_resps++;
                mon_out--;
            end
            if (fill_wen) begin
                fill_t f;
                if (exp_fill.size() == 0) begin
                    n_chk++;
                    $display("FAIL fill_extra: got idx %0d, none expected",
                             fill_idx);
                end else begin
                    f = exp_fill.pop_front();
                    chk("fill_idx", 32'(fill_idx), 32'(f.i));
                    chk("fill_data", fill_data, f.d);
                end
            end
            if (done) begin
                done_t d;
                if (exp_done.size() == 0) begin
                    n_chk++;
                    $display("FAIL done_extra: got done, none expected");
                end else begin
                    d = exp_done.pop_front();
                    chk("done_reqs", 32'(mon_reqs), 32'(d.total));
                    chk("done_resps", 32'(mon_resps), 32'(d.total));
                    chk("done_fills_left", 32'(exp_fill.size()), 32'd0);
                    chk("done_out", 32'(mon_out), 32'd0);
                end
                done_cnt++;
                mon_reqs    = 0;
                mon_resps   = 0;
                mon_wr_acks = 0;
            end
            prev_stall = mem_req_val && !mem_req_rdy;
            prev_req   = '{t: mem_req_type, a: mem_req_addr, d: mem_req_data};
        end
    end

    task automatic push_exp(input logic [1:0] t, input logic [31:0] ev,
                            input logic [31:0] rf);
        bit has_ev = (t == 2'd1 || t == 2'd2);
        bit has_rf = (t != 2'd1);
        if (has_ev)
            for (int i = 0; i < WORDS; i++)
                exp_req.push_back('{t: 1'b1, a: ev + 32'(4 * i),
                                    d: 32'(32'hA0 + i)});
        if (has_rf)
            for (int i = 0; i < WORDS; i++) begin
                exp_req.push_back('{t: 1'b0, a: rf + 32'(4 * i), d: '0});
                exp_fill.push_back('{i: 4'(i), d: rd_data(rf + 32'(4 * i))});
            end
        exp_done.push_back('{total: (has_ev ? 16 : 0) + (has_rf ? 16 : 0),
                             ev: has_ev});
    endtask

    task automatic issue(input logic [1:0] t, input logic [31:0] ev,
                         input logic [31:0] rf);
        bit ok = 0;
        @(negedge clk);
        cmd_val = 1'b1;
        cmd_type = t;
        cmd_evict_addr = ev;
        cmd_refill_addr = rf;
        for (int k = 0; k < 50 && !ok; k++) begin
            #1;
            ok = cmd_rdy;
            @(negedge clk);
        end
        cmd_val = 1'b0;
        if (!ok) begin
            n_chk++;
            $display("FAIL cmd_accept: got cmd_rdy 0 for 50 cycles, need 1");
        end
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 3000 && done_cnt < target; k++) @(negedge clk);
        if (done_cnt < target) begin
            n_chk++;
            $display("FAIL done_timeout: got %0d dones, need %0d",
                     done_cnt, target);
        end
        #3;
        chk("cmd_rdy_after_done", 32'(cmd_rdy), 32'd1);
        repeat (4) @(negedge clk);
        chk("done_once", 32'(done_cnt), 32'(target));
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [31:0] ev,
                           input logic [31:0] rf, input int wl, input int rl,
                           input bit thr);
        int target;
        wr_lat = wl;
        rd_lat = rl;
        throttle = thr;
        push_exp(t, ev, rf);
        target = done_cnt + 1;
        issue(t, ev, rf);
        wait_done(target);
        throttle = 0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("rst_req_val", 32'(mem_req_val), 32'd0);
        chk("rst_req_type", 32'(mem_req_type), 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        chk("rst_req_data", mem_req_data, 32'd0);
        chk("rst_ev_rdy", 32'(ev_data_rdy), 32'd0);
        chk("rst_resp_rdy", 32'(mem_resp_rdy), 32'd0);
        chk("rst_fill_wen", 32'(fill_wen), 32'd0);
        chk("rst_fill_idx", 32'(fill_idx), 32'd0);
        chk("rst_fill_data", fill_data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
    endtask

    initial begin
        int r0;
        bit hit;
        #1;
        chk_reset_outs();
        @(negedge clk);
        #3 reset = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd(2'd0, 32'h0, 32'h1000, 1, 1, 0);
        run_cmd(2'd1, 32'h2000, 32'h0, 1, 1, 0);
        run_cmd(2'd2, 32'h4000, 32'h5000, 10, 1, 0);
        run_cmd(2'd2, 32'h6000, 32'h7000, 3, 2, 1);

        // reset while refill requests are in flight
        wr_lat = 1;
        rd_lat = 1;
        push_exp(2'd0, 32'h0, 32'h1000);
        r0 = rd_hs_cnt;
        hit = 0;
        issue(2'd0, 32'h0, 32'h1000);
        for (int k = 0; k < 100 && !hit; k++) begin
            #3;
            hit = (rd_hs_cnt - r0) >= 7;
            if (!hit) @(negedge clk);
        end
        if (!hit) begin
            n_chk++;
            $display("FAIL reset_setup: got %0d reads, need 7", rd_hs_cnt - r0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk_reset_outs();
        exp_req.delete();
        exp_fill.delete();
        exp_done.delete();
        repeat (2) @(negedge clk);
        #3 reset = 1'b1;
        repeat (2) @(negedge clk);

        run_cmd(2'd0, 32'h0, 32'h1000, 1, 1, 0);
        run_cmd(2'd3, 32'h0, 32'h3000, 1, 1, 0);

        chk("exp_req_empty", 32'(exp_req.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
